// File: rtl/aes128_encrypt_core_if.sv
// Request/result bundle between the bus interface block and the AES-128 core.
// Byte i of every 128-bit field sits at bits [8i:8i+7] (FIPS-197 order).
interface aes128_encrypt_core_if;
    logic [0:127] message;
    logic [0:127] key;
    logic         start;
    logic [0:127] crypte;
    logic         busy;
    logic         done;

    modport master (
        output message, key, start,
        input  crypte, busy, done
    );

    modport slave (
        input  message, key, start,
        output crypte, busy, done
    );
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock, key schedule on the fly.
// Optional AES_ZEROIZE_EN clears state and round key on completion.
module aes128_encrypt_core #(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    aes128_encrypt_core_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LP_LAST = 4'(NR);

    logic [1:0]   r_fsm;
    logic [0:127] r_state;
    logic [0:127] r_rk;
    logic [3:0]   r_rnd;
    logic [0:127] r_crypte;
    logic         r_busy;
    logic         r_done;

    logic [0:127] w_mid;
    logic [0:127] w_last;
    logic [0:127] w_nrk;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // a^254 is the field inverse and maps 0 to 0 without a special case
    function automatic logic [7:0] f_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = f_gmul(sq, sq);
            r  = f_gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = f_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] n);
        logic [7:0] rc;
        case (n)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    always_comb begin : p_round
        logic [7:0] sb [16];
        logic [7:0] sr [16];
        logic [7:0] mc [16];
        logic [7:0] kb [16];
        logic [7:0] nk [16];
        logic [7:0] t  [4];
        logic [7:0] a  [4];
        w_mid  = '0;
        w_last = '0;
        w_nrk  = '0;
        for (int i = 0; i < 16; i++) begin
            kb[i] = r_rk[8*i +: 8];
            sb[i] = f_sbox(r_state[8*i +: 8]);
        end
        // row r of column c takes the byte from column c+r
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = sr[4*c + r];
            for (int r = 0; r < 4; r++) begin
                mc[4*c + r] = f_xtime(a[r])
                            ^ f_xtime(a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                            ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
            end
        end
        for (int j = 0; j < 4; j++) t[j] = f_sbox(kb[12 + (j + 1) % 4]);
        t[0] = t[0] ^ f_rcon(r_rnd);
        for (int j = 0; j < 4; j++) nk[j] = kb[j] ^ t[j];
        for (int w = 1; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                nk[4*w + j] = kb[4*w + j] ^ nk[4*w - 4 + j];
            end
        end
        for (int i = 0; i < 16; i++) begin
            w_nrk[8*i +: 8]  = nk[i];
            w_mid[8*i +: 8]  = mc[i] ^ nk[i];
            w_last[8*i +: 8] = sr[i] ^ nk[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm    <= S_IDLE;
            r_state  <= '0;
            r_rk     <= '0;
            r_rnd    <= 4'd0;
            r_crypte <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= bus.message ^ bus.key;
                        r_rk    <= bus.key;
                        r_rnd   <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_rnd == LP_LAST) begin
                        r_crypte <= w_last;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_fsm    <= S_DONE;
`ifdef AES_ZEROIZE_EN
                        r_state  <= '0;
                        r_rk     <= '0;
`else
                        r_rk     <= w_nrk;
`endif
                    end else begin
                        r_state <= w_mid;
                        r_rk    <= w_nrk;
                        r_rnd   <= r_rnd + 4'd1;
                    end
                end
                S_DONE:  r_fsm <= S_IDLE;
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.crypte = r_crypte;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core against a byte-level AES model.
// Honours AES_ZEROIZE_EN when checking retained key material.
module tb_aes128_encrypt_core;

    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1M = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BM  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C1RK = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    aes128_encrypt_core_if bus ();

    aes128_encrypt_core #(.NR(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c = 8'h63;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                 ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                             input logic [127:0] k);
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] kb [176];
        logic [7:0] t [4];
        logic [7:0] u [4];
        logic [7:0] rc;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) begin
            st[i] = pt[127 - 8*i -: 8];
            kb[i] = k[127 - 8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = kb[i - 4 + j];
            if (i % 16 == 0) begin
                for (int j = 0; j < 4; j++) u[j] = sbox_ref(t[(j + 1) % 4]);
                u[0] = u[0] ^ rc;
                t = u;
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) kb[i + j] = kb[i - 16 + j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = st[i] ^ kb[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox_ref(st[i]);
            for (int row = 0; row < 4; row++) begin
                for (int c = 0; c < 4; c++) begin
                    tmp[row + 4*c] = st[row + 4*((c + row) % 4)];
                end
            end
            st = tmp;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) begin
                        tmp[4*c + row] = gmul(st[4*c + row], 8'h02)
                                       ^ gmul(st[4*c + (row + 1) % 4], 8'h03)
                                       ^ st[4*c + (row + 2) % 4]
                                       ^ st[4*c + (row + 3) % 4];
                    end
                end
                st = tmp;
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ kb[16*r + i];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = st[i];
        return out;
    endfunction

    // Cycle-level expectation: a job is 10 busy cycles then a 1-cycle done.
    logic [127:0] m_crypte = '0;
    logic [127:0] m_result = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_age = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_crypte = '0;
        end else if (m_age == 0) begin
            if (bus.start === 1'b1) begin
                m_result = aes_ref(bus.message, bus.key);
                m_age = 1;
                m_busy = 1'b1;
            end
        end else if (m_age < 10) begin
            m_age++;
        end else if (m_age == 10) begin
            m_crypte = m_result;
            m_busy = 1'b0;
            m_done = 1'b1;
            m_age = 11;
        end else begin
            m_done = 1'b0;
            m_age = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 128'(bus.busy), 128'(m_busy));
            chk("done", 128'(bus.done), 128'(m_done));
            chk("crypte", bus.crypte, m_crypte);
        end
    end

    task automatic run_directed(input string name, input logic [127:0] m,
                                input logic [127:0] k,
                                input logic [127:0] exp);
        int lat;
        int nbusy;
        @(negedge clk);
        bus.message = m;
        bus.key = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.message = 128'(~m);
        lat = 1;
        nbusy = bus.busy ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.busy) nbusy++;
        end
        chk({name, "_latency"}, 128'(lat), 128'd11);
        chk({name, "_busy_cycles"}, 128'(nbusy), 128'd10);
        chk({name, "_crypte"}, bus.crypte, exp);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.busy === 1'b1 || bus.done === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk({name, "_timeout"}, 128'd1, 128'd0);
        @(negedge clk);
    endtask

    initial begin
        int first;
        int second;
        int hold;
        bus.start = 1'b0;
        bus.message = '0;
        bus.key = '0;

        chk("model_c1", aes_ref(C1M, C1K), C1C);
        chk("model_appb", aes_ref(BM, BK), BC);
        chk("model_zero", aes_ref('0, '0), ZC);

        #12;
        chk("rst_crypte", bus.crypte, '0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        run_directed("c1", C1M, C1K, C1C);
`ifdef AES_ZEROIZE_EN
        chk("zeroize_state", 128'(dut.r_state), '0);
        chk("zeroize_rk", 128'(dut.r_rk), '0);
`else
        chk("final_rk", 128'(dut.r_rk), C1RK);
`endif
        wait_idle("c1");
        run_directed("appb", BM, BK, BC);
        wait_idle("appb");
        run_directed("zero", '0, '0, ZC);
        wait_idle("zero");

        // start held high: second job begins one cycle after done
        @(negedge clk);
        bus.message = C1M;
        bus.key = C1K;
        bus.start = 1'b1;
        first = 0;
        second = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 3) bus.message = {$urandom, $urandom, $urandom, $urandom};
            if (c == 5) bus.key = {$urandom, $urandom, $urandom, $urandom};
            if (c == 8) begin
                bus.message = C1M;
                bus.key = C1K;
            end
            if (bus.done === 1'b1) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            if (c == 23) chk("held_crypte", bus.crypte, C1C);
        end
        bus.start = 1'b0;
        chk("held_first_done", 128'(first), 128'd11);
        chk("held_second_done", 128'(second), 128'd23);
        wait_idle("held");

        // asynchronous reset in round 5
        @(negedge clk);
        bus.message = BM;
        bus.key = BK;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_done", 128'(bus.done), 128'd0);
        chk("midrst_crypte", bus.crypte, '0);
        @(negedge clk);
        reset = 1'b0;
        run_directed("after_rst", C1M, C1K, C1C);
        wait_idle("after_rst");

        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            bus.message = {$urandom, $urandom, $urandom, $urandom};
            bus.key = {$urandom, $urandom, $urandom, $urandom};
            bus.start = 1'b1;
            hold = int'($urandom_range(1, 14));
            for (int h = 1; h < hold; h++) begin
                @(negedge clk);
                bus.message = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 1)
                    bus.key = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            bus.start = 1'b0;
            wait_idle("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
